// File: rtl/qtcore_scan_responder_pkg.sv
// Shared definitions for the qtcore scan responder: FSM states, chain geometry,
// CPU field offsets within the capture image and the default unlock key.
package qtcore_scan_responder_pkg;

    localparam int          CHAIN_W_DEF = 160;
    localparam int          KEY_W_DEF   = 16;
    localparam logic [15:0] KEY_DEF     = 16'hBFF9;

    localparam int OFS_STATE = 0;
    localparam int OFS_PC    = 3;
    localparam int OFS_IR    = 8;
    localparam int OFS_ACC   = 16;
    localparam int OFS_MEM   = 24;
    localparam int MEM_BYTES = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // MSB position of memory/IO byte n inside the capture image.
    function automatic int mem_msb(input int n);
        return OFS_MEM + 7 + 8 * n;
    endfunction

endpackage

// File: rtl/qtcore_scan_responder_if.sv
// Serial scan pins between the host (master) and the chip-side responder (slave).
interface qtcore_scan_responder_if;
    logic scan_en;
    logic scan_in;
    logic scan_out;

    modport master (output scan_en, output scan_in, input scan_out);
    modport slave  (input scan_en, input scan_in, output scan_out);
endinterface

// File: rtl/qtcore_scan_bitcounter.sv
// Session bit counter: loads 1 on the capture cycle, then counts shifted bits,
// saturating one past the chain length so long sessions can never alias to a full one.
module qtcore_scan_bitcounter #(
    parameter int CHAIN_W = 160
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inc,
    output logic at_full
);
    localparam int CNT_W = $clog2(CHAIN_W + 2);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(CHAIN_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_W);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(1);
        end else if (inc && count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_full = (count == FULL);

endmodule

// File: rtl/qtcore_scan_responder.sv
// Chip-side scan responder: captures the processor image, shifts it out while the
// host shifts a new one in, and commits it only when the embedded unlock key matches.
module qtcore_scan_responder
    import qtcore_scan_responder_pkg::*;
#(
    parameter int               CHAIN_W = CHAIN_W_DEF,
    parameter int               KEY_W   = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY     = KEY_W'(KEY_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    qtcore_scan_responder_if.slave     scan,
    input  logic                       halt_in,
    input  logic [CHAIN_W-KEY_W-1:0]   cap_data,
    output logic [CHAIN_W-KEY_W-1:0]   upd_data,
    output logic                       upd_valid,
    output logic                       unlocked,
    output logic                       err_len,
    output logic                       err_key,
    output logic                       busy
);
    // state   | meaning
    // IDLE    | no session; scan_out mirrors halt_in
    // SHIFT   | one bit in/out per clock while scan_en is high
    // COMMIT  | single cycle: check length and key, load or flag error

    localparam int DATA_W = CHAIN_W - KEY_W;

    state_t state_q, state_d;
    logic [CHAIN_W-1:0] sr;
    logic [CHAIN_W-1:0] cap_image;
    logic start, shift, at_full, key_ok;

    // Key field is padded with zeros so the key can never be read back.
    assign cap_image = {{KEY_W{1'b0}}, cap_data};
    assign key_ok    = (sr[CHAIN_W-1 -: KEY_W] == KEY);

    qtcore_scan_bitcounter #(.CHAIN_W(CHAIN_W)) u_bitcounter (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .inc     (shift),
        .at_full (at_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        shift     = 1'b0;
        upd_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scan.scan_en) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (scan.scan_en) begin
                    shift = 1'b1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                upd_valid = at_full && key_ok;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture and first shift share a cycle, so the host sees no dead clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (start) begin
            sr <= {cap_image[CHAIN_W-2:0], scan.scan_in};
        end else if (shift) begin
            sr <= {sr[CHAIN_W-2:0], scan.scan_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_data <= '0;
            unlocked <= 1'b0;
            err_len  <= 1'b0;
            err_key  <= 1'b0;
        end else if (state_q == COMMIT) begin
            if (!at_full) begin
                err_len <= 1'b1;
            end else if (key_ok) begin
                upd_data <= sr[DATA_W-1:0];
                unlocked <= 1'b1;
            end else begin
                err_key  <= 1'b1;
                unlocked <= 1'b0;
            end
        end
    end

    always_comb begin
        scan.scan_out = halt_in;
        unique case (state_q)
            IDLE:    scan.scan_out = scan.scan_en ? cap_image[CHAIN_W-1] : halt_in;
            SHIFT:   scan.scan_out = sr[CHAIN_W-1];
            default: scan.scan_out = halt_in;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_qtcore_scan_responder.sv
// Directed and randomized sessions against a chain-level model of the scan responder.
module tb_qtcore_scan_responder;
    import qtcore_scan_responder_pkg::*;

    localparam int          CW  = 160;
    localparam int          DW  = 144;
    localparam logic [15:0] KEY = 16'hBFF9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt_in = 1'b0;
    logic [DW-1:0] cap_data = '0;
    logic [DW-1:0] upd_data;
    logic          upd_valid, unlocked, err_len, err_key, busy;

    qtcore_scan_responder_if sif();

    qtcore_scan_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scan      (sif.slave),
        .halt_in   (halt_in),
        .cap_data  (cap_data),
        .upd_data  (upd_data),
        .upd_valid (upd_valid),
        .unlocked  (unlocked),
        .err_len   (err_len),
        .err_key   (err_key),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic          m_unlocked = 1'b0, m_err_len = 1'b0, m_err_key = 1'b0;
    logic [DW-1:0] m_upd = '0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_cpu(input logic [2:0] st, input logic [4:0] pc,
                                             input logic [7:0] ir, input logic [7:0] acc,
                                             input logic [7:0] mem_base);
        logic [DW-1:0] v = '0;
        v[OFS_STATE +: 3] = st;
        v[OFS_PC +: 5]    = pc;
        v[OFS_IR +: 8]    = ir;
        v[OFS_ACC +: 8]   = acc;
        for (int n = 0; n < 5; n++) v[mem_msb(n) -: 8] = mem_base + 8'(n);
        return v;
    endfunction

    function automatic logic [CW-1:0] rand160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_reset();
        m_unlocked = 1'b0; m_err_len = 1'b0; m_err_key = 1'b0; m_upd = '0;
    endfunction

    // Host sends img MSB-first for n clocks, shifting scan_out into its own LSB.
    task automatic session(input string tag, input logic [CW-1:0] img, input int n,
                           input logic [DW-1:0] cap, output logic [CW-1:0] got);
        logic vld;
        cap_data = cap;
        got = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sif.scan_en = 1'b1;
            sif.scan_in = (k < CW) ? img[CW-1-k] : 1'($urandom_range(0, 1));
            #1;
            got = {got[CW-2:0], sif.scan_out};
        end
        @(negedge clk);
        sif.scan_en = 1'b0;
        vld = (n == CW) && (img[CW-1 -: 16] == KEY);
        @(negedge clk);
        chk({tag, ".upd_valid"}, upd_valid, vld);
        chk({tag, ".busy_commit"}, busy, 1'b1);
        if (n != CW) m_err_len = 1'b1;
        else if (vld) begin m_upd = img[DW-1:0]; m_unlocked = 1'b1; end
        else begin m_err_key = 1'b1; m_unlocked = 1'b0; end
        @(negedge clk);
        chk({tag, ".upd_valid_end"}, upd_valid, 1'b0);
        chk({tag, ".busy_end"}, busy, 1'b0);
        chk({tag, ".upd_data"}, upd_data, m_upd);
        chk({tag, ".unlocked"}, unlocked, m_unlocked);
        chk({tag, ".err_len"}, err_len, m_err_len);
        chk({tag, ".err_key"}, err_key, m_err_key);
    endtask

    initial begin
        logic [CW-1:0] got;
        logic [DW-1:0] cpu, cap;
        int lens [7] = '{150, 159, 160, 160, 160, 161, 300};

        sif.scan_en = 1'b0;
        sif.scan_in = 1'b0;
        #1;
        chk("reset.busy", busy, 1'b0);
        chk("reset.upd_valid", upd_valid, 1'b0);
        chk("reset.upd_data", upd_data, '0);
        chk("reset.flags", {unlocked, err_len, err_key}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        // Load with correct key
        cpu = mk_cpu(3'b001, 5'd1, 8'hE0, 8'h01, 8'hE0);
        session("load", {KEY, cpu}, CW, '0, got);
        chk("load.acc", upd_data[23:16], 8'h01);
        chk("load.mem1", upd_data[39:32], 8'hE1);

        session("short159", {KEY, cpu}, 159, '0, got);

        // Reset in the middle of a session discards it and clears sticky flags
        cap_data = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            sif.scan_en = 1'b1;
            sif.scan_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("midrst.busy_before", busy, 1'b1);
        rst = 1'b1;
        sif.scan_en = 1'b0;
        #1;
        model_reset();
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.upd_valid", upd_valid, 1'b0);
        chk("midrst.flags", {unlocked, err_len, err_key}, 3'b000);
        chk("midrst.upd_data", upd_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.upd_valid_after", upd_valid, 1'b0);
        session("after_rst", {KEY, cpu}, CW, '0, got);

        // Unload: host must see the live image and a zero key field
        cap = mk_cpu(3'b010, 5'd5, 8'hE4, 8'h0B, 8'h30);
        session("unload", {KEY, rand160() >> 16}, CW, cap, got);
        chk("unload.pc", got[7:3], 5'd5);
        chk("unload.ir", got[15:8], 8'hE4);
        chk("unload.acc", got[23:16], 8'h0B);
        chk("unload.key", got[CW-1 -: 16], 16'h0000);
        chk("unload.all", got, {16'h0000, cap});

        session("wrongkey", {16'h1234, cpu}, CW, '0, got);
        session("long170", {KEY, cpu}, 170, '0, got);
        session("long416", {KEY, cpu}, 416, '0, got);

        // Idle: scan_out follows halt_in
        @(negedge clk);
        halt_in = 1'b0;
        #1;
        chk("idle.halt0", sif.scan_out, 1'b0);
        halt_in = 1'b1;
        #1;
        chk("idle.halt1", sif.scan_out, 1'b1);
        chk("idle.busy", busy, 1'b0);

        // Randomized sessions
        for (int i = 0; i < 24; i++) begin
            logic [CW-1:0] img, r;
            int n;
            r = rand160();
            cap = r[DW-1:0];
            img = rand160();
            if ($urandom_range(0, 1) == 1) img[CW-1 -: 16] = KEY;
            n = lens[$urandom_range(0, 6)];
            halt_in = 1'($urandom_range(0, 1));
            session($sformatf("rand%0d", i), img, n, cap, got);
            if (n == CW) chk($sformatf("rand%0d.unload", i), got, {16'h0000, cap});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qtcore_scan_responder.md
Name: qtcore_scan_responder

Overview:
Target (responder) end of the qtcore serial scan interface, i.e. the chip-side counterpart of a scan host. It shifts one bit per clock through a CHAIN_W-bit chain, capturing the live processor state at the start of a session and committing the shifted image back at the end. An embedded KEY_W-bit unlock field must match before any commit takes effect. It sits between the top-level pin mux (scan_en/scan_in/scan_out) and the processor's state/PC/IR/ACC/memory registers.

Parameters:
CHAIN_W, 160, total chain length in bits (24 CPU bits + 15x8 memory/IO bits + KEY_W)
KEY_W, 16, width of the unlock field at the chain MSB end
KEY, 16'hBFF9, unlock value expected in chain bits [CHAIN_W-1 -: KEY_W]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
scan_en  in  1  scan session active (already de-inverted at the top level)
scan_in  in  1  serial data from host
scan_out  out  1  serial data to host; halt_in when idle
halt_in  in  1  processor halt flag, muxed onto scan_out outside sessions
cap_data  in  CHAIN_W-KEY_W  live processor image; bit 0 = state[0]
upd_data  out  CHAIN_W-KEY_W  committed image for the processor registers
upd_valid  out  1  one-cycle pulse; processor loads upd_data
unlocked  out  1  sticky: last commit attempt carried a correct key
err_len  out  1  sticky: a session ended with bit count != CHAIN_W
err_key  out  1  sticky: a full-length session carried a wrong key
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-session): state IDLE, shift reg = 0, bit count = 0, upd_data = 0, upd_valid = 0, unlocked = 0, err_len = 0, err_key = 0. No commit for an interrupted session.
- FSM states: IDLE, SHIFT, COMMIT. scan_en is sampled on rising clk.
- IDLE, scan_en=1: sr <= {cap_data padded with KEY_W zero bits at MSB, shifted left by 1, scan_in in LSB}; count <= 1; -> SHIFT. Capture and first shift occur in the same cycle, so a host clocking on every scan_en-high edge sees no dead cycle.
- SHIFT, scan_en=1: sr <= {sr[CHAIN_W-2:0], scan_in}; count increments, saturating at CHAIN_W+1.
- SHIFT, scan_en=0: -> COMMIT (no shift).
- COMMIT (exactly one cycle), always -> IDLE:
  - count != CHAIN_W: set err_len; no update.
  - count == CHAIN_W and sr[CHAIN_W-1 -: KEY_W] == KEY: upd_data <= sr[CHAIN_W-KEY_W-1:0]; upd_valid = 1 for this cycle; unlocked <= 1.
  - count == CHAIN_W and key mismatch: set err_key; unlocked <= 0; no update.
- scan_out is combinational:
  - scan_en=0 and state IDLE: halt_in.
  - scan_en=1 and state IDLE: MSB of the capture image (0, from the key padding).
  - SHIFT: sr[CHAIN_W-1].
  - COMMIT: halt_in.
- Key bits are never readable from cap_data. An unload always returns zeros in the key field.
- Chain ordering: a host sending its image MSB-first and shifting captured bits into its LSB holds the old chain after exactly CHAIN_W clocks.
- A scan_en rising edge during COMMIT is ignored for that cycle. The session starts on the following cycle from IDLE.
- err_len and err_key clear only on reset.

Decomposition:
- Shared package: FSM state enum (IDLE/SHIFT/COMMIT), CPU field offsets (state 2:0, PC 7:3, IR 15:8, ACC 23:16, MEM[n] at 31+8n), default KEY constant.
- One sub-module: qtcore_scan_bitcounter (saturating counter, clear/inc, ==CHAIN_W compare).

Test Plan:
- Reset mid-SHIFT after 50 bits -> state IDLE, no upd_valid, all flags 0; a subsequent full session with correct key commits normally.
- Load: 160 clocks, state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4, key BFF9 -> one upd_valid pulse the cycle after scan_en falls; upd_data[23:16]=01, [39:32]=E1; unlocked=1.
- Unload: cap_data with PC=5, IR=E4, ACC=0B -> host's captured bits [7:3]=5, [15:8]=E4, [23:16]=0B, key field 0000.
- Wrong key 0x1234 on a full-length session -> no upd_valid, err_key=1, unlocked=0.
- Short session of 159 clocks -> err_len=1, no upd_valid. Long session of 170 clocks -> err_len=1, and the count saturates without wrapping to an accidental 160.
- Idle with halt_in toggled 0->1 -> scan_out follows 0->1 combinationally; busy=0.
